// File: rtl/normalize_round_pkg.sv
// Shared constants and the stage-1 payload type for the binary32 normalize/round back end.
package normalize_round_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int SUM_W   = MAN_W + 5;
  localparam int SIG_W   = MAN_W + 4;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam int GUARD  = 2;
  localparam int ROUND  = 1;
  localparam int STICKY = 0;

  // sig is {hidden, fraction, G, R, S}; exp carries one spare bit for carry/overflow
  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [SIG_W-1:0] sig;
    logic             zero;
    logic             uf;
  } s1_payload_t;

endpackage

// File: rtl/normalize_round_lzc27.sv
// Combinational leading-zero counter over a 27-bit significand.
module lzc27 (
  input  logic [26:0] din,
  output logic [4:0]  count,
  output logic        all_zero
);

  // Scan upward so the highest set bit writes the count last
  always_comb begin
    count    = 5'd27;
    all_zero = (din == 27'd0);
    for (int i = 0; i < 27; i++) begin
      count = din[i] ? 5'(26 - i) : count;
    end
  end

endmodule

// File: rtl/normalize_round.sv
// Two-stage normalize and round-to-nearest-even back end of the single-precision adder.
module normalize_round
  import normalize_round_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_inexact
);

  s1_payload_t s1_r;
  s1_payload_t s1_next_s;
  logic        s1_valid_r;
  logic        s2_adv_s;
  logic [4:0]  lz_s;
  logic        all_zero_s;

  logic        lsb_s;
  logic        g_s;
  logic        rs_s;
  logic        round_up_s;
  logic [24:0] mant_inc_s;
  logic [8:0]  exp_rnd_s;
  logic [31:0] res_s;
  logic        ov_s;
  logic        uf_s;
  logic        ix_s;

  assign s2_adv_s = !out_valid || out_ready;
  assign in_ready = !s1_valid_r || s2_adv_s;

  lzc27 u_lzc (
    .din      (in_sum[SIG_W-1:0]),
    .count    (lz_s),
    .all_zero (all_zero_s)
  );

  // Stage-1 normalization: carry right-shift, cancellation left-shift, zero and flush detection
  always_comb begin
    s1_next_s.sign = in_sign;
    s1_next_s.exp  = {1'b0, in_exp};
    s1_next_s.sig  = in_sum[SIG_W-1:0];
    s1_next_s.zero = 1'b0;
    s1_next_s.uf   = 1'b0;
    if (in_sum[SUM_W-1]) begin
      s1_next_s.sig = {in_sum[SUM_W-1:2], |in_sum[1:0]};
      s1_next_s.exp = {1'b0, in_exp} + 9'd1;
    end else if (all_zero_s) begin
      s1_next_s.sign = 1'b0;
      s1_next_s.exp  = 9'd0;
      s1_next_s.sig  = 27'd0;
      s1_next_s.zero = 1'b1;
    end else if ({4'd0, lz_s} >= {1'b0, in_exp}) begin
      s1_next_s.exp = 9'd0;
      s1_next_s.sig = 27'd0;
      s1_next_s.uf  = 1'b1;
    end else begin
      s1_next_s.sig = in_sum[SIG_W-1:0] << lz_s;
      s1_next_s.exp = {1'b0, in_exp} - {4'd0, lz_s};
    end
  end

  // Stage-2 round-to-nearest-even, mantissa carry renormalization and overflow packing
  always_comb begin
    lsb_s      = s1_r.sig[GUARD+1];
    g_s        = s1_r.sig[GUARD];
    rs_s       = s1_r.sig[ROUND] | s1_r.sig[STICKY];
    round_up_s = g_s & (rs_s | lsb_s);
    mant_inc_s = {1'b0, s1_r.sig[SIG_W-1:GUARD+1]} + {24'd0, round_up_s};
    exp_rnd_s  = s1_r.exp + {8'd0, mant_inc_s[24]};
    res_s      = 32'd0;
    ov_s       = 1'b0;
    uf_s       = 1'b0;
    ix_s       = 1'b0;
    if (s1_r.zero) begin
      res_s = 32'd0;
    end else if (s1_r.uf) begin
      res_s = {s1_r.sign, 31'd0};
      uf_s  = 1'b1;
      ix_s  = 1'b1;
    end else if (exp_rnd_s >= 9'(EXP_MAX)) begin
      res_s = {s1_r.sign, 8'hFF, 23'd0};
      ov_s  = 1'b1;
      ix_s  = 1'b1;
    end else begin
      res_s = {s1_r.sign, exp_rnd_s[7:0],
               mant_inc_s[24] ? mant_inc_s[23:1] : mant_inc_s[22:0]};
      ix_s  = g_s | rs_s;
    end
  end

  // Stage-1 register: loads on accept, empties when its beat moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid_r <= 1'b1;
      s1_r       <= s1_next_s;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Output register: holds result and flags while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_result    <= res_s;
        out_overflow  <= ov_s;
        out_underflow <= uf_s;
        out_inexact   <= ix_s;
      end
    end
  end

endmodule

// File: tb/tb_normalize_round.sv
// Self-checking bench for normalize_round: directed vector table, backpressure/reset sequences, random stream vs. model.
module tb_normalize_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int passed = 0;
  int total  = 0;
  int emit_cnt = 0;
  bit sb_en = 1'b0;
  logic [34:0] exp_q[$];

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, inexact}
  } vec_t;

  vec_t vecs[9];

  normalize_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_sum        (in_sum),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value-level reference: treat the sum as an integer scaled so bit 26 weighs 2^(exp-127)
  function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [27:0] sm);
    int msb;
    int be;
    int k;
    logic [63:0] mant;
    logic [63:0] rem;
    logic [63:0] half;
    logic inexact;
    msb = -1;
    inexact = 1'b0;
    for (int i = 0; i < 28; i++) if (sm[i]) msb = i;
    if (msb < 0) return {32'd0, 3'b000};
    be = int'(e) + msb - 26;
    if (be <= 0) return {s, 31'd0, 3'b011};
    if (msb >= 23) begin
      k    = msb - 23;
      mant = 64'(sm) >> k;
      rem  = 64'(sm) & ((64'd1 << k) - 64'd1);
      half = (k > 0) ? (64'd1 << (k - 1)) : 64'd0;
      inexact = (rem != 64'd0);
      if (k > 0 && (rem > half || (rem == half && mant[0]))) mant = mant + 64'd1;
    end else begin
      mant = 64'(sm) << (23 - msb);
    end
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      be   = be + 1;
    end
    if (be >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    return {s, 8'(be), mant[22:0], 2'b00, inexact};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // One clock cycle: drive at negedge, then observe the handshakes that the next posedge will take
  task automatic step(input logic iv, input logic s, input logic [7:0] e, input logic [27:0] sm,
                      input logic ordy, output logic acc);
    logic [34:0] front;
    @(negedge clk);
    in_valid  = iv;
    in_sign   = s;
    in_exp    = e;
    in_sum    = sm;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (sb_en && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL spurious_out: got result %h with no beat outstanding", out_result);
      end else begin
        front = exp_q[0];
        chk("stream_result", {29'd0, out_result, out_overflow, out_underflow, out_inexact}, {29'd0, front});
        if (out_ready) begin
          front = exp_q.pop_front();
          emit_cnt++;
        end
      end
    end
    if (sb_en && acc) exp_q.push_back(model(s, e, sm));
  endtask

  initial begin
    logic acc;
    logic [27:0] bp_sum[4];
    int idx;
    int stale;
    int mode;
    logic [27:0] rsum;

    vecs[0] = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000};
    vecs[1] = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 3'b000};
    vecs[2] = '{1'b1, 8'd5,   28'h0000008, 32'h80000000, 3'b011};
    vecs[3] = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b001};
    vecs[4] = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001};
    vecs[5] = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 3'b001};
    vecs[6] = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 3'b101};
    vecs[7] = '{1'b1, 8'd127, 28'h0000000, 32'h00000000, 3'b000};
    vecs[8] = '{1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101};

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_sum = 28'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_result", 64'(out_result), 64'd0);
    chk("reset_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
    rst = 1'b0;

    // Directed vectors, one at a time, with latency checks
    for (int v = 0; v < 9; v++) begin
      step(1'b1, vecs[v].sign, vecs[v].exp, vecs[v].sum, 1'b1, acc);
      chk("vec_accept", 64'(acc), 64'd1);
      step(1'b0, 1'b0, 8'd1, 28'd0, 1'b1, acc);
      chk("vec_latency_early", 64'(out_valid), 64'd0);
      step(1'b0, 1'b0, 8'd1, 28'd0, 1'b1, acc);
      chk("vec_out_valid", 64'(out_valid), 64'd1);
      chk("vec_result", 64'(out_result), 64'(vecs[v].res));
      chk("vec_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(vecs[v].flags));
    end

    // Backpressure: four beats back-to-back, downstream stalled for three cycles
    sb_en = 1'b1;
    emit_cnt = 0;
    bp_sum[0] = 28'h8000000; bp_sum[1] = 28'h4000004; bp_sum[2] = 28'h400000C; bp_sum[3] = 28'h7FFFFFC;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      step(idx < 4, 1'b0, 8'd127, bp_sum[idx % 4], 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_accepted_before_stall", 64'(idx), 64'd2);
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() != 0); c++) begin
      step(idx < 4, 1'b0, 8'd127, bp_sum[idx % 4], 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_emitted", 64'(emit_cnt), 64'd4);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random stream against the value-level model
    for (int c = 0; c < 400; c++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: rsum = 28'($urandom);
        1: rsum = 28'($urandom) | 28'h8000000;
        2: rsum = 28'($urandom) >> $urandom_range(1, 27);
        3: rsum = 28'($urandom) | 28'h4000000;
        default: rsum = ($urandom_range(0, 7) == 0) ? 28'd0 : 28'($urandom) >> $urandom_range(20, 27);
      endcase
      step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(1, 254)), rsum,
           $urandom_range(0, 9) < 7, acc);
    end
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(1'b0, 1'b0, 8'd1, 28'd0, 1'b1, acc);
    chk("rand_drain_empty", 64'(exp_q.size()), 64'd0);
    sb_en = 1'b0;

    // Reset with two beats in flight
    step(1'b1, 1'b0, 8'd127, 28'h8000000, 1'b0, acc);
    step(1'b1, 1'b0, 8'd127, 28'h4000004, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flight_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flight_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, 8'd1, 28'd0, 1'b1, acc);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
